// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver that deframes the asynchronous rxd line
// and buffers bytes in a first-word-fall-through FIFO with valid/ready output.
module uart_rx_fifo #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        rxd,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [AW:0] o_count,
  output logic        o_frame_err,
  output logic        o_overrun
);

  localparam int CPB  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF = CPB / 2;

  localparam logic [11:0]   CPB_LAST  = 12'(CPB - 1);
  localparam logic [11:0]   HALF_LAST = 12'(HALF - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          rx_meta;
  logic          rx_s;
  logic [11:0]   cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;

  logic          half_hit;
  logic          bit_hit;
  logic          cnt_clr;
  logic          shift_en;
  logic          good_stop;
  logic          bad_stop;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Synchronizer resets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  assign half_hit = (cnt == HALF_LAST);
  assign bit_hit  = (cnt == CPB_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: if (half_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (bit_hit && (idx == 3'd7)) state_nxt = STOP;
      STOP:  if (bit_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Holding cnt at zero while idle means START always begins counting from 0.
  always_comb begin
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      IDLE:  cnt_clr = 1'b1;
      START: cnt_clr = half_hit;
      DATA: begin
        cnt_clr  = bit_hit;
        shift_en = bit_hit;
      end
      STOP: begin
        good_stop = bit_hit & rx_s;
        bad_stop  = bit_hit & ~rx_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 12'd1;
      end
      if (state == START) begin
        idx <= '0;
      end else if (shift_en) begin
        shift[idx] <= rx_s;
        idx        <= idx + 3'd1;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign pop  = o_valid & i_ready;
  assign push = good_stop & ((count != FULL_CNT) | pop);

  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem[wr_ptr] <= shift;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= bad_stop;
      o_overrun   <= good_stop & ~push;
    end
  end

  // Head byte is gated by valid so stale storage never shows after reset.
  assign o_valid = (count != '0);
  assign o_count = count;
  assign o_data  = o_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed, table-driven bench for uart_rx_fifo using a
// shortened bit period (CPB=33, HALF=16) so the full plan stays short.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 3250000;
  localparam int BAUD   = 100000;
  localparam int DEPTH  = 16;
  localparam int CPB    = 33;
  localparam int HALF   = 16;
  localparam int NVEC   = 6;

  logic       clk_clk;
  logic       reset_reset_n;
  logic       rxd;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [4:0] o_count;
  logic       o_frame_err;
  logic       o_overrun;

  int checks;
  int failures;
  int frame_pulses;
  int overrun_pulses;
  int both_pulses;
  int lat_seen;
  int f0;
  int v0;
  logic [7:0] pop_log[$];

  typedef struct {
    logic [7:0] tx;
    logic       stop_bit;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [4:0] exp_count;
    int         exp_frame;
  } vec_t;

  vec_t vecs[NVEC];

  uart_rx_fifo #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .DEPTH (DEPTH)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .rxd          (rxd),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_count      (o_count),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  // Pulses and accepted bytes are logged away from the active edge.
  always @(negedge clk_clk) begin
    if (o_frame_err) frame_pulses++;
    if (o_overrun) overrun_pulses++;
    if (o_frame_err && o_overrun) both_pulses++;
    if (o_valid && i_ready) pop_log.push_back(o_data);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_pop(input string name, input logic [7:0] expected);
    if (pop_log.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: got no popped byte expected 0x%0h", name, expected);
    end else begin
      checkOutput(name, 32'(pop_log.pop_front()), 32'(expected));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) @(posedge clk_clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(posedge clk_clk);
      #1;
    end
    rxd = stop_bit;
    repeat (CPB) @(posedge clk_clk);
    #1;
    rxd = 1'b1;
  endtask

  task automatic pop_one();
    i_ready = 1'b1;
    @(posedge clk_clk);
    #1;
    i_ready = 1'b0;
  endtask

  task automatic drain(input int budget);
    i_ready = 1'b1;
    for (int k = 0; k < budget && o_count != 5'd0; k++) begin
      @(posedge clk_clk);
      #1;
    end
    i_ready = 1'b0;
    checkOutput("drain_count", 32'(o_count), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    f0 = frame_pulses;
    v0 = overrun_pulses;
    send_frame(v.tx, v.stop_bit);
    checkOutput($sformatf("vec%0d_valid", n), 32'(o_valid), 32'(v.exp_valid));
    if (v.exp_valid) checkOutput($sformatf("vec%0d_data", n), 32'(o_data), 32'(v.exp_data));
    checkOutput($sformatf("vec%0d_count", n), 32'(o_count), 32'(v.exp_count));
    checkOutput($sformatf("vec%0d_frame", n), 32'(frame_pulses - f0), 32'(v.exp_frame));
    checkOutput($sformatf("vec%0d_overrun", n), 32'(overrun_pulses - v0), 32'd0);
    if (v.exp_valid) begin
      pop_one();
      check_pop($sformatf("vec%0d_pop", n), v.exp_data);
      checkOutput($sformatf("vec%0d_count_after", n), 32'(o_count), 32'd0);
    end
    idle(2 * CPB);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    frame_pulses   = 0;
    overrun_pulses = 0;
    both_pulses    = 0;
    lat_seen       = 0;
    rxd            = 1'b1;
    i_ready        = 1'b0;
    reset_reset_n  = 1'b0;

    vecs[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 5'd1, 0};
    vecs[1] = '{8'h81, 1'b1, 1'b1, 8'h81, 5'd1, 0};
    vecs[2] = '{8'h12, 1'b0, 1'b0, 8'h00, 5'd0, 1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 5'd1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 5'd1, 0};
    vecs[5] = '{8'hC3, 1'b0, 1'b0, 8'h00, 5'd0, 1};

    repeat (3) @(posedge clk_clk);
    #1;
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_count", 32'(o_count), 32'd0);
    checkOutput("rst_data", 32'(o_data), 32'd0);
    checkOutput("rst_frame", 32'(o_frame_err), 32'd0);
    checkOutput("rst_overrun", 32'(o_overrun), 32'd0);
    reset_reset_n = 1'b1;
    idle(4);

    // Single byte: o_valid expected 3+HALF+9*CPB edges after the falling edge.
    f0 = frame_pulses;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int k = 1; k <= 400 && lat_seen == 0; k++) begin
          @(posedge clk_clk);
          #1;
          if (o_valid) lat_seen = k;
        end
      end
    join
    checks++;
    if (lat_seen < 2 + HALF + 9 * CPB || lat_seen > 4 + HALF + 9 * CPB) begin
      failures++;
      $display("[TB] FAIL single_latency: got %0d cycles expected %0d +/-1", lat_seen, 3 + HALF + 9 * CPB);
    end
    checkOutput("single_data", 32'(o_data), 32'hA5);
    checkOutput("single_count", 32'(o_count), 32'd1);
    checkOutput("single_frame", 32'(frame_pulses - f0), 32'd0);
    pop_one();
    check_pop("single_pop", 8'hA5);
    checkOutput("single_count_after", 32'(o_count), 32'd0);
    idle(CPB);

    for (int n = 0; n < NVEC; n++) applyStimulus(vecs[n], n);

    // Back-to-back stream with the consumer always ready.
    pop_log.delete();
    f0 = frame_pulses;
    v0 = overrun_pulses;
    i_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(2 * CPB);
    i_ready = 1'b0;
    check_pop("b2b_pop0", 8'h00);
    check_pop("b2b_pop1", 8'hFF);
    check_pop("b2b_pop2", 8'h55);
    check_pop("b2b_pop3", 8'h3C);
    checkOutput("b2b_count", 32'(o_count), 32'd0);
    checkOutput("b2b_frame", 32'(frame_pulses - f0), 32'd0);
    checkOutput("b2b_overrun", 32'(overrun_pulses - v0), 32'd0);

    // Glitch shorter than half a bit must be rejected as a false start.
    f0 = frame_pulses;
    v0 = overrun_pulses;
    rxd = 1'b0;
    idle(HALF - 4);
    rxd = 1'b1;
    idle(11 * CPB);
    checkOutput("glitch_count", 32'(o_count), 32'd0);
    checkOutput("glitch_frame", 32'(frame_pulses - f0), 32'd0);
    checkOutput("glitch_overrun", 32'(overrun_pulses - v0), 32'd0);

    // Overrun: 17 bytes into a 16-entry FIFO with no consumer.
    pop_log.delete();
    v0 = overrun_pulses;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
    checkOutput("ovr_count16", 32'(o_count), 32'd16);
    checkOutput("ovr_none_yet", 32'(overrun_pulses - v0), 32'd0);
    send_frame(8'h10, 1'b1);
    checkOutput("ovr_pulse", 32'(overrun_pulses - v0), 32'd1);
    checkOutput("ovr_count_full", 32'(o_count), 32'd16);
    drain(100);
    for (int i = 0; i < 16; i++) check_pop($sformatf("ovr_drain%0d", i), 8'(i));
    checkOutput("ovr_log_empty", 32'(pop_log.size()), 32'd0);
    idle(CPB);

    // Full FIFO with a pop landing exactly on the stop-bit sample cycle.
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1);
    checkOutput("fp_count16", 32'(o_count), 32'd16);
    pop_log.delete();
    v0 = overrun_pulses;
    fork
      send_frame(8'h30, 1'b1);
      begin
        repeat (2 + HALF + 9 * CPB) @(posedge clk_clk);
        #1;
        i_ready = 1'b1;
        @(posedge clk_clk);
        #1;
        i_ready = 1'b0;
      end
    join
    checkOutput("fp_overrun", 32'(overrun_pulses - v0), 32'd0);
    checkOutput("fp_count", 32'(o_count), 32'd16);
    check_pop("fp_popped", 8'h20);
    drain(100);
    for (int i = 0; i < 16; i++) check_pop($sformatf("fp_drain%0d", i), 8'(8'h21 + i));
    idle(CPB);

    // Asynchronous reset during data bit 4 with one byte already queued.
    send_frame(8'h5A, 1'b1);
    checkOutput("rstmid_pre_count", 32'(o_count), 32'd1);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (2 + HALF + 4 * CPB + CPB / 2) @(posedge clk_clk);
        #3;
        reset_reset_n = 1'b0;
        #1;
        checkOutput("rstmid_valid", 32'(o_valid), 32'd0);
        checkOutput("rstmid_count", 32'(o_count), 32'd0);
        checkOutput("rstmid_data", 32'(o_data), 32'd0);
        checkOutput("rstmid_frame", 32'(o_frame_err), 32'd0);
        checkOutput("rstmid_overrun", 32'(o_overrun), 32'd0);
      end
    join
    idle(2);
    reset_reset_n = 1'b1;
    idle(4);
    pop_log.delete();
    f0 = frame_pulses;
    send_frame(8'h7E, 1'b1);
    checkOutput("rstmid_next_valid", 32'(o_valid), 32'd1);
    checkOutput("rstmid_next_data", 32'(o_data), 32'h7E);
    checkOutput("rstmid_next_count", 32'(o_count), 32'd1);
    checkOutput("rstmid_next_frame", 32'(frame_pulses - f0), 32'd0);
    pop_one();
    check_pop("rstmid_next_pop", 8'h7E);

    checkOutput("pulses_exclusive", 32'(both_pulses), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Hardware UART receiver with a receive FIFO, on the same RS-232 line (UART_RXD) that feeds the Nios/Qsys UART.
- Lets RTL datapaths consume host bytes directly, without going through the soft-core UART.
- Samples the asynchronous line, deframes 8N1 characters, and buffers them in a first-word-fall-through FIFO with a valid/ready output.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate.
- DEPTH, 16, FIFO entries; power of two, ≥2.
- Derived, not overridable:
  - CPB = (CLK_HZ + BAUD/2)/BAUD (434 at defaults).
  - HALF = CPB/2 (217 at defaults).
  - AW = log2(DEPTH).

Ports:
- clk_clk  in  1  system clock (CLOCK_50 domain).
- reset_reset_n  in  1  asynchronous active-low reset.
- rxd  in  1  raw serial input, idle high, asynchronous to clk_clk.
- o_data  out  8  FIFO head byte; valid only while o_valid=1.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts the head byte when o_valid&i_ready.
- o_count  out  AW+1  current FIFO occupancy, 0..DEPTH.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun  out  1  one-cycle pulse: byte completed while FIFO full and no pop in that cycle.

Behaviour:
- Clock and reset:
  - One clock: clk_clk.
  - reset_reset_n is asynchronous, active-low.
- Reset values:
  - All outputs 0 (o_data=8'h00).
  - FIFO empty.
  - FSM in IDLE.
  - Synchronizer flops set to 1, so reset does not fake a start bit.
- Reset mid-character: the partial byte is discarded and FIFO contents are lost.
- Input synchronizer: rxd passes through 2 flops; rx_s is the second-flop output. All decisions use rx_s.
- Bit counter: 12-bit cycle counter cnt; 3-bit bit index idx.
- FSM:
  - IDLE: when rx_s=0, load cnt=0 and go START.
  - START: count to HALF-1, then sample.
    - rx_s=1 → false start; return to IDLE, no pulse, nothing stored.
    - rx_s=0 → cnt=0, idx=0, go DATA.
  - DATA: each time cnt reaches CPB-1, sample rx_s into shift[idx], LSB first, and reset cnt.
    - After idx=7 is sampled, go STOP.
  - STOP: at cnt=CPB-1, sample rx_s.
    - rx_s=1 → push byte.
    - rx_s=0 → o_frame_err pulses the next cycle; byte discarded.
    - Either way, return to IDLE in the same transition.
    - This allows back-to-back characters with the next start edge arriving in the second half of the stop bit.
- Latency:
  - Stop-bit sample occurs 2 + HALF + 9·CPB cycles after rxd falls.
  - o_valid rises 1 cycle after the sample when the FIFO was empty.
- FIFO:
  - Registered storage with wr_ptr/rd_ptr of AW bits.
  - count register of AW+1 bits; pointers wrap modulo DEPTH.
  - pop = o_valid & i_ready.
  - push = good stop & (count<DEPTH | pop).
- Simultaneous push and pop:
  - count is unchanged.
  - When full, the pop frees the slot, so the push succeeds and no overrun occurs.
- Full FIFO: a good byte completes with count=DEPTH and no pop → byte dropped, o_overrun pulses 1 cycle, FIFO unchanged.
- Empty FIFO: o_valid=0; i_ready ignored; pointers do not move.
- o_data is combinational from mem[rd_ptr]. It is stable while o_valid=1 and no pop.
- o_count equals the registered count.
- o_frame_err and o_overrun are registered pulses and never assert in the same cycle.

Test Plan:
- Single byte: drive 0xA5 at 115200 8N1 with i_ready=0 → o_valid=1, o_data=0xA5, o_count=1, within 1 cycle of the stop sample (±1 cycle of 2+217+9·434 after the falling edge).
- Back-to-back stream: 0x00,0xFF,0x55,0x3C with no idle gap and i_ready=1 → four pops in order, no error pulses, o_count returns to 0.
- Glitch and framing:
  - 100-cycle low glitch on rxd → no byte, no pulses.
  - 0x12 with the stop bit held low → o_frame_err single pulse, o_count stays 0.
- Overrun: i_ready=0, send 17 bytes 0x00..0x10 → o_count=16, one o_overrun pulse on byte 0x10; then drain reads 0x00..0x0F in order.
- Full with simultaneous pop: FIFO full, assert i_ready for exactly the cycle the 17th byte completes → no o_overrun, o_count stays 16, last entry equals the new byte.
- Async reset mid-byte: assert reset_reset_n=0 during DATA bit 4 → outputs 0 immediately; after release, the next clean byte 0x7E is received correctly.
